// File: rtl/palindrome_pkg.sv
// Shared types and helpers for the palindrome checker.
// State encoding, compare-mode constants and byte reversal.
package palindrome_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

  localparam logic MODE_WORD = 1'b0;
  localparam logic MODE_BYTE = 1'b1;

  localparam int MAX_W = 1024;

  // Reverses the byte order of the low 'width' bits; upper bits return 0.
  function automatic logic [MAX_W-1:0] byte_reverse(
    input logic [MAX_W-1:0] w,
    input int               width
  );
    logic [MAX_W-1:0] r;
    int               n;
    r = '0;
    n = width / 8;
    for (int i = 0; i < MAX_W / 8; i++) begin
      if (i < n) r[8*i +: 8] = w[8*(n-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/palindrome_regfile.sv
// Register file for the palindrome checker.
// Two combinational read ports, one synchronous write port, no reset.
module palindrome_regfile
  import palindrome_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/palindrome_engine.sv
// Two-pointer palindrome checker over a write-loaded register file.
// One pair comparison per cycle, word or byte granularity.
module palindrome_engine
  import palindrome_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             go,
  input  logic             mode,
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    ending,
  output logic             busy,
  output logic             done,
  output logic             palindrome,
  output logic             range_err,
  output logic [AW-1:0]    mismatch_addr,
  output logic [AW-1:0]    compares
);

  state_t           state, state_nx;
  logic [AW-1:0]    front, front_nx;
  logic [AW-1:0]    back, back_nx;
  logic             mode_q, mode_nx;
  logic             pal_nx, rerr_nx;
  logic [AW-1:0]    maddr_nx, cmp_nx;
  logic [WIDTH-1:0] rd_a, rd_b, b_cmp;
  logic             match, last, bad_range;

  palindrome_regfile #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_rf (
    .clock  (clock),
    .we     (we & ~busy),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(front),
    .raddr_b(back),
    .rdata_a(rd_a),
    .rdata_b(rd_b)
  );

  assign busy = (state == CHECK);
  assign done = (state == DONE);

  assign b_cmp = (mode_q == MODE_BYTE)
               ? WIDTH'(byte_reverse(MAX_W'(rd_b), WIDTH))
               : rd_b;
  assign match = (rd_a == b_cmp);
  assign last  = ({1'b0, front} + (AW+1)'(1)) >= {1'b0, back};

  assign bad_range = (base > ending) || (32'(ending) >= DEPTH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      front         <= '0;
      back          <= '0;
      mode_q        <= MODE_WORD;
      palindrome    <= 1'b0;
      range_err     <= 1'b0;
      mismatch_addr <= '0;
      compares      <= '0;
    end else begin
      state         <= state_nx;
      front         <= front_nx;
      back          <= back_nx;
      mode_q        <= mode_nx;
      palindrome    <= pal_nx;
      range_err     <= rerr_nx;
      mismatch_addr <= maddr_nx;
      compares      <= cmp_nx;
    end
  end

  // A bad range still spends one CHECK cycle, but performs no compare.
  always_comb begin
    state_nx = state;
    front_nx = front;
    back_nx  = back;
    mode_nx  = mode_q;
    pal_nx   = palindrome;
    rerr_nx  = range_err;
    maddr_nx = mismatch_addr;
    cmp_nx   = compares;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_nx = CHECK;
          cmp_nx   = '0;
          maddr_nx = '0;
          pal_nx   = 1'b0;
          if (bad_range) begin
            rerr_nx = 1'b1;
          end else begin
            rerr_nx  = 1'b0;
            front_nx = base;
            back_nx  = ending;
            mode_nx  = mode;
          end
        end
      end
      CHECK: begin
        if (range_err) begin
          state_nx = DONE;
        end else begin
          cmp_nx = compares + AW'(1);
          if (!match) begin
            maddr_nx = front;
            state_nx = DONE;
          end else if (last) begin
            pal_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            front_nx = front + AW'(1);
            back_nx  = back - AW'(1);
          end
        end
      end
      DONE: begin
        if (!go) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_palindrome_engine.sv
// Self-checking bench for palindrome_engine.
// Expected results queued at start, popped when done is seen.
module tb_palindrome_engine;

  typedef struct packed {
    logic       pal;
    logic       rerr;
    logic [4:0] maddr;
    logic [4:0] cmps;
    int         lat;
  } res_t;

  logic        clock;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        go;
  logic        mode;
  logic [4:0]  base;
  logic [4:0]  ending;
  logic        busy;
  logic        done;
  logic        palindrome;
  logic        range_err;
  logic [4:0]  mismatch_addr;
  logic [4:0]  compares;

  int   n_cmp;
  int   n_bad;
  res_t exp_q [$];

  palindrome_engine #(
    .WIDTH(32),
    .DEPTH(32)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .we           (we),
    .waddr        (waddr),
    .wdata        (wdata),
    .go           (go),
    .mode         (mode),
    .base         (base),
    .ending       (ending),
    .busy         (busy),
    .done         (done),
    .palindrome   (palindrome),
    .range_err    (range_err),
    .mismatch_addr(mismatch_addr),
    .compares     (compares)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic wr(input int a, input logic [31:0] d);
    we    = 1'b1;
    waddr = a[4:0];
    wdata = d;
    @(posedge clock);
    @(negedge clock);
    we = 1'b0;
  endtask

  task automatic start_and_wait(input int b, input int e, input logic m,
                                output res_t r);
    int lat;
    go     = 1'b1;
    base   = b[4:0];
    ending = e[4:0];
    mode   = m;
    @(posedge clock);
    lat = 0;
    forever begin
      @(negedge clock);
      if (done) break;
      if (lat > 200) begin
        lat = -1;
        break;
      end
      @(posedge clock);
      lat++;
    end
    r.pal   = palindrome;
    r.rerr  = range_err;
    r.maddr = mismatch_addr;
    r.cmps  = compares;
    r.lat   = lat;
    go = 1'b0;
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic res_t mk(input logic p, input logic re,
                              input int ma, input int c, input int l);
    res_t r;
    r.pal   = p;
    r.rerr  = re;
    r.maddr = ma[4:0];
    r.cmps  = c[4:0];
    r.lat   = l;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    go    = 1'b0;
    mode  = 1'b0;
    base  = '0;
    ending = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({busy, done, palindrome, range_err, mismatch_addr, compares} !== 14'd0) begin
      $display("FAIL reset: got %b %b %b %b %0d %0d, want all 0",
               busy, done, palindrome, range_err, mismatch_addr, compares);
      n_bad++;
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic run_case(input string name, input int b, input int e,
                          input logic m, input res_t exp);
    res_t got, want;
    exp_q.push_back(exp);
    start_and_wait(b, e, m, got);
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      $display("FAIL %s: got %p, want %p", name, got, want);
      n_bad++;
    end
  endtask

  task automatic test_even_word();
    wr(11, 32'h12344321);
    wr(12, 32'h0);
    wr(13, 32'h0);
    wr(14, 32'h12344321);
    run_case("even_word", 11, 14, 1'b0, mk(1, 0, 0, 2, 2));
  endtask

  task automatic test_odd_word();
    wr(2, 32'hCAFEBABE);
    wr(3, 32'hFFFFFFFF);
    wr(4, 32'h0B3D1E55);
    wr(5, 32'hFFFFFFFF);
    wr(6, 32'hCAFEBABE);
    run_case("odd_word", 2, 6, 1'b0, mk(1, 0, 0, 3, 3));
  endtask

  task automatic test_fail_word();
    wr(7, 32'h33333333);
    wr(8, 32'hC001D0D3);
    wr(9, 32'hFFFFFFFF);
    wr(10, 32'hBAB3D0D3);
    wr(11, 32'h33333333);
    run_case("fail_word", 7, 11, 1'b0, mk(0, 0, 8, 2, 2));
  endtask

  task automatic test_byte_mode();
    wr(0, 32'h11223344);
    wr(1, 32'h44332211);
    run_case("byte_pair", 0, 1, 1'b1, mk(1, 0, 0, 1, 1));
    run_case("word_pair", 0, 1, 1'b0, mk(0, 0, 0, 1, 1));
    // 12 34 43 21 reversed is 21 43 34 12, so not a byte palindrome
    wr(5, 32'h12344321);
    run_case("byte_single_no", 5, 5, 1'b1, mk(0, 0, 5, 1, 1));
    wr(5, 32'h12343412);
    run_case("byte_single_yes", 5, 5, 1'b1, mk(1, 0, 0, 1, 1));
  endtask

  task automatic test_range_err();
    run_case("range_err", 9, 3, 1'b0, mk(0, 1, 0, 0, 1));
  endtask

  task automatic test_write_drop();
    res_t got, want;
    wr(11, 32'h12344321);
    wr(14, 32'h12344321);
    exp_q.push_back(mk(1, 0, 0, 2, 2));
    fork
      start_and_wait(11, 14, 1'b0, got);
      begin
        @(posedge clock);
        @(negedge clock);
        we    = 1'b1;
        waddr = 5'd12;
        wdata = 32'hDEADBEEF;
        @(posedge clock);
        @(negedge clock);
        we = 1'b0;
      end
    join
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      $display("FAIL write_drop_run: got %p, want %p", got, want);
      n_bad++;
    end
    run_case("write_drop_readback", 11, 14, 1'b0, mk(1, 0, 0, 2, 2));
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      wr(16 + i, 32'h0101_0101 * (i + 1));
      wr(31 - i, 32'h0101_0101 * (i + 1));
    end
    go     = 1'b1;
    base   = 5'd16;
    ending = 5'd31;
    mode   = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    go    = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, palindrome, range_err, mismatch_addr, compares} !== 14'd0) begin
      $display("FAIL reset_mid: got %b %b %b %b %0d %0d, want all 0",
               busy, done, palindrome, range_err, mismatch_addr, compares);
      n_bad++;
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
      n_bad++;
    end
    run_case("reset_rerun", 16, 31, 1'b0, mk(1, 0, 0, 8, 8));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_even_word();
    test_odd_word();
    test_fail_word();
    test_byte_mode();
    test_range_err();
    test_write_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
